// File: rtl/soc_interrupt_sequencer_if.sv
// SoC_InterruptBus: priority-encoded request from the interrupt controller to the CPU.
interface SoC_InterruptBus;
    logic       irq;
    logic [4:0] irq_id;

    modport Handler    (input  irq, input  irq_id);
    modport Controller (output irq, output irq_id);
endinterface

// File: rtl/soc_interrupt_sequencer.sv
// soc_interrupt_sequencer: waits for an instruction boundary, performs trap entry
// (save PC, capture ID, redirect, clear pulse) and blocks re-entry until mret.
// Optional feature macro: SOC_INT_VECTORED_EN (vectored handler addresses; default is direct mode).
module soc_interrupt_sequencer (
    input  logic                clk,
    input  logic                res,
    SoC_InterruptBus.Handler    int_bus,
    input  logic                global_int_en,
    input  logic                instr_boundary,
    input  logic [31:0]         cur_pc,
    input  logic [31:0]         vector_base,
    input  logic                mret,
    output logic                take_int,
    output logic [31:0]         vector_pc,
    output logic [31:0]         int_clears,
    output logic                in_handler,
    output logic [4:0]          active_id,
    output logic [31:0]         return_pc,
    output logic                ret_valid
);

    localparam int unsigned ID_W = 5;
    localparam int unsigned PC_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        ENTER   = 3'd2,
        HANDLER = 3'd3,
        EXIT    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              take_int_q, take_int_d;
    logic              in_handler_q, in_handler_d;
    logic              ret_valid_q, ret_valid_d;
    logic [PC_W-1:0]   int_clears_q, int_clears_d;
    logic [ID_W-1:0]   active_id_q, active_id_d;
    logic [PC_W-1:0]   return_pc_q, return_pc_d;
    logic [PC_W-1:0]   vector_pc_q, vector_pc_d;

    logic              req_c;
    logic [PC_W-1:0]   base_aligned_c;
    logic [PC_W-1:0]   vector_target_c;

    // Request qualified by the core's global enable; low two base bits forced to zero.
    assign req_c          = int_bus.irq & global_int_en;
    assign base_aligned_c = vector_base & ~PC_W'(3);

    // Handler address for the ID currently on the bus.
`ifdef SOC_INT_VECTORED_EN
    assign vector_target_c = base_aligned_c + (PC_W'(int_bus.irq_id) << 2);
`else
    assign vector_target_c = base_aligned_c;
`endif

    // State and registered outputs; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= IDLE;
            take_int_q   <= 1'b0;
            in_handler_q <= 1'b0;
            ret_valid_q  <= 1'b0;
            int_clears_q <= '0;
            active_id_q  <= '0;
            return_pc_q  <= '0;
            vector_pc_q  <= '0;
        end else begin
            state_q      <= state_d;
            take_int_q   <= take_int_d;
            in_handler_q <= in_handler_d;
            ret_valid_q  <= ret_valid_d;
            int_clears_q <= int_clears_d;
            active_id_q  <= active_id_d;
            return_pc_q  <= return_pc_d;
            vector_pc_q  <= vector_pc_d;
        end
    end

    // Next state, capture at the boundary, and outputs decoded from the next state.
    always_comb begin
        state_d      = state_q;
        active_id_d  = active_id_q;
        return_pc_d  = return_pc_q;
        vector_pc_d  = vector_pc_q;
        take_int_d   = 1'b0;
        in_handler_d = 1'b0;
        ret_valid_d  = 1'b0;
        int_clears_d = '0;

        case (state_q)
            IDLE: begin
                if (req_c) state_d = ARMED;
            end
            ARMED: begin
                if (!req_c) begin
                    state_d = IDLE;
                end else if (instr_boundary) begin
                    state_d     = ENTER;
                    active_id_d = int_bus.irq_id;
                    return_pc_d = cur_pc;
                    vector_pc_d = vector_target_c;
                end
            end
            ENTER:   state_d = HANDLER;
            HANDLER: begin
                if (mret) state_d = EXIT;
            end
            EXIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        take_int_d   = (state_d == ENTER);
        in_handler_d = (state_d == HANDLER);
        ret_valid_d  = (state_d == EXIT);
        if (take_int_d) int_clears_d = PC_W'(1) << active_id_d;
    end

    assign take_int   = take_int_q;
    assign in_handler = in_handler_q;
    assign ret_valid  = ret_valid_q;
    assign int_clears = int_clears_q;
    assign active_id  = active_id_q;
    assign return_pc  = return_pc_q;
    assign vector_pc  = vector_pc_q;

endmodule

// File: tb/tb_soc_interrupt_sequencer.sv
// Directed bench for soc_interrupt_sequencer with a per-cycle behavioural model.
module tb_soc_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        res;
    logic        global_int_en;
    logic        instr_boundary;
    logic [31:0] cur_pc;
    logic [31:0] vector_base;
    logic        mret;
    logic        take_int;
    logic [31:0] vector_pc;
    logic [31:0] int_clears;
    logic        in_handler;
    logic [4:0]  active_id;
    logic [31:0] return_pc;
    logic        ret_valid;

    int checks = 0;
    int errors = 0;
    int lat;
    logic saw_take;

    SoC_InterruptBus bus ();

    soc_interrupt_sequencer dut (
        .clk            (clk),
        .res            (res),
        .int_bus        (bus),
        .global_int_en  (global_int_en),
        .instr_boundary (instr_boundary),
        .cur_pc         (cur_pc),
        .vector_base    (vector_base),
        .mret           (mret),
        .take_int       (take_int),
        .vector_pc      (vector_pc),
        .int_clears     (int_clears),
        .in_handler     (in_handler),
        .active_id      (active_id),
        .return_pc      (return_pc),
        .ret_valid      (ret_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the core should see, expressed as the phase of the current trap.
    // phase 0 = quiet, 1 = request pending a boundary, 2 = redirect cycle,
    // 3 = servicing, 4 = return cycle.
    int          m_phase;
    logic [4:0]  m_id;
    logic [31:0] m_ret;
    logic [31:0] m_vec;

    function automatic logic [31:0] handler_addr(input logic [31:0] base, input logic [4:0] id);
`ifdef SOC_INT_VECTORED_EN
        return (base / 32'd4) * 32'd4 + 32'(id) * 32'd4;
`else
        return (base / 32'd4) * 32'd4 + 32'd0 * 32'(id);
`endif
    endfunction

    always @(posedge clk or posedge res) begin
        if (res) begin
            m_phase = 0;
            m_id    = 5'd0;
            m_ret   = 32'd0;
            m_vec   = 32'd0;
        end else begin
            if (m_phase == 2)                      m_phase = 3;
            else if (m_phase == 3)                 m_phase = mret ? 4 : 3;
            else if (m_phase == 4)                 m_phase = 0;
            else if (!(bus.irq && global_int_en))  m_phase = 0;
            else if (m_phase == 0)                 m_phase = 1;
            else if (instr_boundary) begin
                m_phase = 2;
                m_id    = bus.irq_id;
                m_ret   = cur_pc;
                m_vec   = handler_addr(vector_base, bus.irq_id);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (!res) begin
            chk("take_int",   {31'd0, take_int},   {31'd0, m_phase == 2});
            chk("in_handler", {31'd0, in_handler}, {31'd0, m_phase == 3});
            chk("ret_valid",  {31'd0, ret_valid},  {31'd0, m_phase == 4});
            chk("int_clears", int_clears, (m_phase == 2) ? (32'd1 << m_id) : 32'd0);
            chk("active_id",  {27'd0, active_id}, {27'd0, m_id});
            chk("return_pc",  return_pc, m_ret);
            chk("vector_pc",  vector_pc, m_vec);
            if (take_int) saw_take = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_take(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!take_int && cyc < budget);
        chk("take_int_wait", {31'd0, take_int}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b1;
        bus.irq = 1'b0;
        bus.irq_id = 5'd0;
        global_int_en = 1'b0;
        instr_boundary = 1'b0;
        cur_pc = 32'd0;
        vector_base = 32'h8000;
        mret = 1'b0;
        saw_take = 1'b0;

        // Reset state
        tick(3);
        chk("rst_take_int",   {31'd0, take_int}, 32'd0);
        chk("rst_in_handler", {31'd0, in_handler}, 32'd0);
        chk("rst_int_clears", int_clears, 32'd0);
        chk("rst_vector_pc",  vector_pc, 32'd0);
        res = 1'b0;
        tick(1);

        // Basic entry: id 5, boundary two cycles after the request
        bus.irq = 1'b1; bus.irq_id = 5'd5; global_int_en = 1'b1; cur_pc = 32'h100;
        tick(2);
        instr_boundary = 1'b1;
        tick(1);
        chk("basic_take", {31'd0, take_int}, 32'd1);
        chk("basic_clears", int_clears, 32'h20);
        chk("basic_ret_pc", return_pc, 32'h100);
`ifdef SOC_INT_VECTORED_EN
        chk("basic_vec", vector_pc, 32'h8014);
`else
        chk("basic_vec", vector_pc, 32'h8000);
`endif
        instr_boundary = 1'b0; bus.irq = 1'b0; cur_pc = 32'h200;
        tick(1);
        chk("basic_in_handler", {31'd0, in_handler}, 32'd1);
        tick(3);

        // Return
        mret = 1'b1;
        tick(1);
        mret = 1'b0;
        chk("ret_valid", {31'd0, ret_valid}, 32'd1);
        chk("ret_pc", return_pc, 32'h100);
        chk("ret_in_handler", {31'd0, in_handler}, 32'd0);
        tick(1);
        chk("ret_valid_once", {31'd0, ret_valid}, 32'd0);

        // Spurious mret while idle
        mret = 1'b1;
        tick(1);
        mret = 1'b0;
        chk("spurious_mret", {31'd0, ret_valid}, 32'd0);
        tick(2);

        // Priority change while armed
        bus.irq = 1'b1; bus.irq_id = 5'd7; cur_pc = 32'h340;
        tick(1);
        bus.irq_id = 5'd2; instr_boundary = 1'b1;
        tick(1);
        chk("prio_take", {31'd0, take_int}, 32'd1);
        chk("prio_id", {27'd0, active_id}, 32'd2);
        chk("prio_clears", int_clears, 32'h4);
        tick(3);

        // Re-entry with irq and boundary held: take_int 3 cycles after ret_valid
        mret = 1'b1;
        tick(1);
        mret = 1'b0;
        chk("reent_ret_valid", {31'd0, ret_valid}, 32'd1);
        wait_take(10, lat);
        chk("reent_latency", 32'(lat), 32'd3);
        bus.irq = 1'b0; instr_boundary = 1'b0;
        tick(2);
        mret = 1'b1;
        tick(1);
        mret = 1'b0;
        tick(2);

        // Withdrawal before the boundary
        saw_take = 1'b0;
        bus.irq = 1'b1; bus.irq_id = 5'd3;
        tick(1);
        bus.irq = 1'b0;
        tick(1);
        instr_boundary = 1'b1;
        tick(3);
        chk("withdraw_no_take", {31'd0, saw_take}, 32'd0);
        instr_boundary = 1'b0;

        // Masked request for 10 cycles
        global_int_en = 1'b0; bus.irq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instr_boundary = i[0];
            tick(1);
        end
        chk("mask_no_take", {31'd0, saw_take}, 32'd0);
        bus.irq = 1'b0; instr_boundary = 1'b0;
        tick(1);
        global_int_en = 1'b1;
        tick(1);

        // Reset in the middle of a handler, then normal entry after release
        bus.irq = 1'b1; bus.irq_id = 5'd9; instr_boundary = 1'b1; cur_pc = 32'h4440;
        tick(2);
        chk("mid_take", {31'd0, take_int}, 32'd1);
        tick(1);
        chk("mid_in_handler", {31'd0, in_handler}, 32'd1);
        chk("mid_id", {27'd0, active_id}, 32'd9);
        #2;
        res = 1'b1;
        #1;
        chk("async_in_handler", {31'd0, in_handler}, 32'd0);
        chk("async_id", {27'd0, active_id}, 32'd0);
        chk("async_ret_pc", return_pc, 32'd0);
        chk("async_vec", vector_pc, 32'd0);
        chk("async_take", {31'd0, take_int}, 32'd0);
        chk("async_clears", int_clears, 32'd0);
        chk("async_ret_valid", {31'd0, ret_valid}, 32'd0);
        tick(2);
        res = 1'b0;
        wait_take(6, lat);
        chk("post_rst_id", {27'd0, active_id}, 32'd9);
        chk("post_rst_clears", int_clears, 32'h200);
        bus.irq = 1'b0; instr_boundary = 1'b0;
        tick(2);
        mret = 1'b1;
        tick(1);
        mret = 1'b0;
        tick(2);

        // Vector address wrap-around with id 31
        vector_base = 32'hFFFF_FFF3; bus.irq = 1'b1; bus.irq_id = 5'd31; cur_pc = 32'hABC0;
        instr_boundary = 1'b1;
        wait_take(6, lat);
        chk("wrap_clears", int_clears, 32'h8000_0000);
`ifdef SOC_INT_VECTORED_EN
        chk("wrap_vec", vector_pc, 32'h0000_006C);
`else
        chk("wrap_vec", vector_pc, 32'hFFFF_FFF0);
`endif
        bus.irq = 1'b0; instr_boundary = 1'b0;
        tick(2);
        chk("wrap_vec_stable", vector_pc, handler_addr(32'hFFFF_FFF0, 5'd31));
        chk("wrap_ret_pc", return_pc, 32'hABC0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_interrupt_sequencer.md
# soc_interrupt_sequencer

CPU-side receiver of the SoC interrupt bus. Watches the priority-encoded request from the interrupt controller, waits for an instruction boundary, and performs trap entry: saves the return PC, captures the interrupt ID, redirects the core to the handler vector, and pulses the matching clear line back to the controller. Blocks further entries until the core signals return, so at most one interrupt is active at a time.

## Interface
- No parameters.
- clk  in  1  system clock
- res  in  1  reset, asynchronous, active-high
- int_bus  SoC_InterruptBus.Handler  —  carries irq (1) and irq_id (5) from the interrupt controller
- global_int_en  in  1  core global interrupt enable
- instr_boundary  in  1  core is between instructions and may be redirected this cycle
- cur_pc  in  32  PC of the next instruction to execute, valid when instr_boundary=1
- vector_base  in  32  handler base address; bits [1:0] ignored, treated as 0
- mret  in  1  one-cycle pulse: handler return
- take_int  out  1  one-cycle pulse: core must jump to vector_pc
- vector_pc  out  32  handler target address
- int_clears  out  32  one-hot clear pulse to controller, bit = captured ID
- in_handler  out  1  high while an interrupt is being serviced
- active_id  out  5  ID of the interrupt being serviced
- return_pc  out  32  saved PC
- ret_valid  out  1  one-cycle pulse: core must jump to return_pc

## Operation
- Five states: IDLE, ARMED, ENTER, HANDLER, EXIT. All outputs registered.
- IDLE: if irq && global_int_en -> ARMED.
- ARMED: if !(irq && global_int_en) -> IDLE (request withdrawn, nothing captured). Else if instr_boundary -> capture active_id <= irq_id and return_pc <= cur_pc in that cycle, -> ENTER. The ID is sampled at the boundary cycle, not the arming cycle, so a higher-priority request that arrives meanwhile wins.
- ENTER (1 cycle): take_int=1, int_clears=1<<active_id, vector_pc valid; -> HANDLER.
- HANDLER: in_handler=1; irq and global_int_en ignored; mret -> EXIT.
- EXIT (1 cycle): ret_valid=1, in_handler=0; -> IDLE.
- mret outside HANDLER is ignored. instr_boundary outside ARMED is ignored.
- The clear pulse does not override a trigger that is still active. The controller re-latches, and the request re-arms after EXIT.
- Reset (any state, including mid-handler): state IDLE; take_int, ret_valid, in_handler=0; int_clears=0; active_id=0; return_pc=0; vector_pc=0.

## Timing
- Edge E: irq && global_int_en seen in IDLE -> ARMED from E+1.
- Boundary sampled at edge B in ARMED -> take_int and int_clears high for exactly the cycle after B; in_handler high from B+2.
- Minimum IRQ-to-take_int latency: 2 cycles (arm edge, then boundary edge).
- mret at edge M in HANDLER -> ret_valid high for the cycle after M; earliest re-arm at M+2; earliest next take_int M+3 cycles later.
- vector_pc and return_pc are stable from the take_int cycle until the next capture.

## Configuration
- SOC_INT_VECTORED_EN defined: vector_pc = {vector_base[31:2],2'b00} + active_id*4 (32-bit wrap-around).
- SOC_INT_VECTORED_EN undefined: vector_pc = {vector_base[31:2],2'b00} for every ID (direct mode). The handler reads active_id to dispatch.

## Test plan
- Basic entry: irq=1, id=5, global_int_en=1, instr_boundary high two cycles later, cur_pc=0x100, vector_base=0x8000 -> take_int pulse; int_clears=0x20; return_pc=0x100; vector_pc=0x8014 (vectored) or 0x8000 (direct).
- Priority change while ARMED: id=7 at arming, id=2 when instr_boundary rises -> active_id=2, int_clears=0x4.
- Withdrawal and mask: irq drops before the boundary -> state returns to IDLE, no take_int. Also irq=1 with global_int_en=0 for 10 cycles -> no take_int.
- Return and re-entry: mret in HANDLER -> ret_valid=1 one cycle with return_pc=0x100. irq held high -> next take_int no earlier than 3 cycles after mret. A spurious mret in IDLE produces no ret_valid.
- Reset mid-handler: assert res asynchronously in HANDLER with active_id=9 -> all outputs 0 immediately, with no clock edge needed. After release with irq=1 -> normal entry.
- Wrap: vector_base=0xFFFFFFF0, id=31, vectored -> vector_pc=0x0000006C.
